sample_pacer: RTL and testbench

SAMPLE_PACER -- requirements
Module: sample_pacer

---
 rtl/sample_pacer.sv | 108 ++++++++++
 tb/tb_sample_pacer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// Sample pacer: buffers upstream samples in a small FIFO and releases one
// sample every PERIOD enabled clocks as a one-cycle new-data strobe.
module sample_pacer #(
  parameter int DATA_W = 18,
  parameter int PERIOD = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic                     Enable_i,
  input  logic [DATA_W-1:0]        Data_i,
  input  logic                     DataValid_i,
  output logic                     DataReady_o,
  input  logic                     ClrUnderrun_i,
  output logic [DATA_W-1:0]        Data_o,
  output logic                     DataNd_o,
  output logic                     Underrun_o,
  output logic [$clog2(DEPTH):0]   Level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              nd_q, nd_d;
  logic              underrun_q, underrun_d;

  logic tick;
  logic empty;
  logic push;
  logic pop;

  always_comb begin
    tick  = Enable_i && (cnt_q == CNT_MAX);
    empty = (level_q == '0);
    // Ready comes from registered occupancy only, so a pop on this edge
    // never frees a slot for a push on the same edge.
    push  = DataValid_i && (level_q < LVL_MAX);
    pop   = tick && !empty;
  end

  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    data_d     = data_q;
    nd_d       = tick;
    underrun_d = underrun_q;

    if (!Enable_i || tick) cnt_d = '0;
    else                   cnt_d = cnt_q + CNT_W'(1);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (tick) data_d = empty ? '0 : mem_q[rd_ptr_q];

    // An empty-FIFO strobe takes priority over a clear on the same edge.
    if (tick && empty)      underrun_d = 1'b1;
    else if (ClrUnderrun_i) underrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_q     <= '0;
      nd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_q     <= data_d;
      nd_q       <= nd_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the storage array has no reset; zeroing the occupancy and pointers
  // already discards its contents, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge Clk_i) begin
    if (push) mem_q[wr_ptr_q] <= Data_i;
  end

  assign DataReady_o = (level_q < LVL_MAX);
  assign Data_o      = data_q;
  assign DataNd_o    = nd_q;
  assign Underrun_o  = underrun_q;
  assign Level_o     = level_q;

endmodule

// File: tb/tb_sample_pacer.sv
// Scoreboard bench for sample_pacer: a queue-based reference model predicts
// every strobe, and a negedge monitor compares whatever the DUT presents.
module tb_sample_pacer;

  localparam int DATA_W = 18;
  localparam int PERIOD = 16;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              und;
  } strobe_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid = 1'b0;
  logic              clr = 1'b0;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              nd;
  logic              underrun;
  logic [LVL_W-1:0]  level;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] model_fifo[$];
  int                model_run = 0;
  logic              model_und = 1'b0;
  strobe_t           sb[$];
  logic [DATA_W-1:0] last_data = '0;

  sample_pacer #(.DATA_W(DATA_W), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
    .Clk_i        (clk),
    .Rst_i        (rst_n),
    .Enable_i     (enable),
    .Data_i       (data_in),
    .DataValid_i  (valid),
    .DataReady_o  (ready),
    .ClrUnderrun_i(clr),
    .Data_o       (data_out),
    .DataNd_o     (nd),
    .Underrun_o   (underrun),
    .Level_o      (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs that edge samples.
  task automatic model_step();
    logic              tick;
    logic              can_push;
    logic [DATA_W-1:0] v;
    strobe_t           s;
    tick = 1'b0;
    if (enable) begin
      model_run++;
      if (model_run == PERIOD) begin
        tick = 1'b1;
        model_run = 0;
      end
    end else begin
      model_run = 0;
    end
    can_push = (model_fifo.size() < DEPTH);
    if (tick) begin
      if (model_fifo.size() > 0) begin
        v = model_fifo.pop_front();
        if (clr) model_und = 1'b0;
      end else begin
        v = '0;
        model_und = 1'b1;
      end
      s.data = v;
      s.und  = model_und;
      sb.push_back(s);
    end else if (clr) begin
      model_und = 1'b0;
    end
    if (valid && can_push) model_fifo.push_back(data_in);
  endtask

  task automatic cycle(input logic en, input logic vld, input logic [DATA_W-1:0] d, input logic c);
    enable  = en;
    valid   = vld;
    data_in = d;
    clr     = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) cycle(en, 1'b0, '0, 1'b0);
  endtask

  // Assert reset just after an edge (possibly mid-strobe) and check the
  // asynchronous effect before the next edge arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    model_fifo.delete();
    sb.delete();
    model_run = 0;
    model_und = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_nd", nd, 0);
    check("rst_data", data_out, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", ready, 1);
    enable = 1'b0;
    valid  = 1'b0;
    clr    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares strobes against the scoreboard and status every cycle.
  always @(negedge clk) begin
    strobe_t e;
    if (!rst_n) last_data = '0;
    if (nd) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_data", data_out, e.data);
        check("strobe_underrun", underrun, e.und);
        last_data = e.data;
      end
    end else begin
      check("data_hold", data_out, last_data);
    end
    check("level", level, model_fifo.size());
    check("ready", ready, model_fifo.size() < DEPTH);
    check("underrun", underrun, model_und);
  end

  initial begin
    #2;
    do_reset();

    // Basic pacing: 1,2,3 back-to-back while enabled
    cycle(1'b1, 1'b1, 18'd1, 1'b0);
    cycle(1'b1, 1'b1, 18'd2, 1'b0);
    cycle(1'b1, 1'b1, 18'd3, 1'b0);
    idle(50, 1'b1);
    do_reset();

    // Backpressure: fill while disabled, fifth sample must be refused
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DATA_W'(10 + i), 1'b0);
    check("full_level", level, DEPTH);
    check("full_ready", ready, 0);
    idle(70, 1'b1);

    // Underrun continues from the drained FIFO, then clear it
    idle(20, 1'b1);
    check("underrun_sticky", underrun, 1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("underrun_cleared", underrun, 0);
    do_reset();

    // Simultaneous push and pop at level 2 on the tick edge
    cycle(1'b1, 1'b1, 18'h00aa, 1'b0);
    cycle(1'b1, 1'b1, 18'h00bb, 1'b0);
    idle(13, 1'b1);
    cycle(1'b1, 1'b1, 18'h00cc, 1'b0);
    check("pushpop_level", level, 2);
    idle(40, 1'b1);

    // Signed samples reproduced bit-exact
    cycle(1'b1, 1'b1, 18'h10000, 1'b0);
    cycle(1'b1, 1'b1, 18'h30000, 1'b0);
    idle(40, 1'b1);
    do_reset();

    // Reset mid-period with three samples queued
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DATA_W'(20 + i), 1'b0);
    idle(7, 1'b1);
    check("pre_reset_level", level, 3);
    do_reset();
    idle(20, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4,
              DATA_W'($urandom), $urandom_range(0, 19) == 0);
      end
    end

    idle(2, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
